// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has fixed priority,
// and results from a long-latency unit queue in a small FIFO behind it. A
// starvation counter occasionally stalls writeback for one cycle so that a
// queued result can drain.
module wb_port_arbiter #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   output logic             wb_stall,
   input  logic             lu_valid,
   output logic             lu_ready,
   input  logic [4:0]       lu_rd,
   input  logic [WIDTH-1:0] lu_data,
   output logic             lu_pending,
   output logic             rf_we,
   output logic [4:0]       rf_a3,
   output logic [WIDTH-1:0] rf_wd
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT_C  = SW'(STARVE_LIMIT);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef struct packed {
      logic [4:0]       rd;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   entry_t head;
   logic   wb_req;
   logic   not_empty;
   logic   starve_hit;
   logic   grant_fifo;
   logic   grant_wb;
   logic   can_push;
   logic   push;
   logic   pop;

   // Grant decision and port outputs; everything is held quiet while reset is high.
   always_comb begin
      head       = mem_q[rd_ptr_q];
      wb_req     = wb_valid && (wb_rd != 5'd0);
      not_empty  = (count_q != '0);
      starve_hit = not_empty && wb_req && (starve_cnt_q == LIMIT_C);
      grant_fifo = starve_hit || (!wb_req && not_empty);
      grant_wb   = wb_req && !starve_hit;
      can_push   = (count_q < DEPTH_C);
      push       = lu_valid && can_push && (lu_rd != 5'd0);
      pop        = grant_fifo;

      rf_we      = 1'b0;
      rf_a3      = 5'd0;
      rf_wd      = '0;
      wb_stall   = 1'b0;
      lu_ready   = 1'b0;
      lu_pending = 1'b0;
      if (!reset) begin
         lu_ready   = can_push;
         lu_pending = not_empty;
         wb_stall   = starve_hit;
         if (grant_fifo) begin
            rf_we = 1'b1;
            rf_a3 = head.rd;
            rf_wd = head.data;
         end else if (grant_wb) begin
            rf_we = 1'b1;
            rf_a3 = wb_rd;
            rf_wd = wb_data;
         end
      end
   end

   // Next FIFO contents, pointers, occupancy and starvation count.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {lu_rd, lu_data};
      end

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      starve_cnt_d = starve_cnt_q;
      if (pop || !not_empty) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT_C) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   // State registers; reset empties the FIFO and discards queued results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_cnt_q <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule
